draw_scheduler: RTL and testbench

DRAW_SCHEDULER -- requirements
Module: draw_scheduler

---
 rtl/draw_scheduler.sv | 169 ++++++++++++++++
 tb/tb_draw_scheduler.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_scheduler.sv
// Frame scheduler for four sprite drawers: enables them one at a time in index order,
// pipelines their pixels to the VGA adapter and abandons a drawer that never finishes.
module draw_scheduler #(
  parameter int TIMEOUT = 20000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [3:0]  draw_mask,
  output logic [3:0]  en,
  input  logic [3:0]  done_in,
  input  logic [31:0] x_in,
  input  logic [27:0] y_in,
  input  logic [11:0] colour_in,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        plot,
  output logic        busy,
  output logic        frame_done,
  output logic [3:0]  timeout_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SELECT, RUN, DRAIN, FINISH} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    mask_reg, mask_next;
  logic [1:0]    idx_reg, idx_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          pending_reg, pending_next;
  logic [3:0]    err_reg, err_next;

  logic [7:0]    vga_x_reg;
  logic [6:0]    vga_y_reg;
  logic          plot_reg;
  logic [1:0]    pix_idx_reg;

  logic [7:0]    x_arr [4];
  logic [6:0]    y_arr [4];
  logic [2:0]    c_arr [4];
  logic [3:0]    hit;
  logic [3:0]    en_sel;
  logic [1:0]    first_hit;
  logic          running;
  logic          done_ok;
  logic          at_limit;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_drawer
      assign x_arr[gi]  = x_in[8*gi +: 8];
      assign y_arr[gi]  = y_in[7*gi +: 7];
      assign c_arr[gi]  = colour_in[3*gi +: 3];
      // Candidates for the scan: requested drawers at or above the current index.
      assign hit[gi]    = mask_reg[gi] && (idx_reg <= 2'(gi));
      assign en_sel[gi] = (idx_reg == 2'(gi));
    end
  endgenerate

  always_comb begin
    first_hit = 2'd0;
    casez (hit)
      4'b???1: first_hit = 2'd0;
      4'b??10: first_hit = 2'd1;
      4'b?100: first_hit = 2'd2;
      4'b1000: first_hit = 2'd3;
      default: first_hit = 2'd0;
    endcase
  end

  assign running    = (state_reg == RUN);
  assign en         = running ? en_sel : 4'b0000;
  assign busy       = (state_reg != IDLE);
  assign frame_done = (state_reg == FINISH);
  // A drawer's done may still be high from the previous frame during its first enabled cycle.
  assign done_ok    = (cnt_reg != '0) && done_in[idx_reg];
  assign at_limit   = (cnt_reg == CNT_LAST);

  always_comb begin
    state_next   = state_reg;
    mask_next    = mask_reg;
    idx_next     = idx_reg;
    cnt_next     = cnt_reg;
    pending_next = pending_reg;
    err_next     = err_reg;

    if (frame_start && busy && !pending_reg)
      pending_next = 1'b1;

    case (state_reg)
      IDLE: begin
        if (frame_start || pending_reg) begin
          mask_next    = draw_mask;
          idx_next     = 2'd0;
          pending_next = 1'b0;
          state_next   = SELECT;
        end
      end
      SELECT: begin
        if (|hit) begin
          idx_next   = first_hit;
          cnt_next   = '0;
          state_next = RUN;
        end else begin
          state_next = FINISH;
        end
      end
      RUN: begin
        if (done_ok) begin
          state_next = DRAIN;
        end else if (at_limit) begin
          err_next   = err_reg | en_sel;
          state_next = DRAIN;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DRAIN: begin
        if (idx_reg == 2'd3) begin
          state_next = FINISH;
        end else begin
          idx_next   = idx_reg + 1'b1;
          state_next = SELECT;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      mask_reg    <= 4'b0000;
      idx_reg     <= 2'd0;
      cnt_reg     <= '0;
      pending_reg <= 1'b0;
      err_reg     <= 4'b0000;
      vga_x_reg   <= 8'd0;
      vga_y_reg   <= 7'd0;
      plot_reg    <= 1'b0;
      pix_idx_reg <= 2'd0;
    end else begin
      state_reg   <= state_next;
      mask_reg    <= mask_next;
      idx_reg     <= idx_next;
      cnt_reg     <= cnt_next;
      pending_reg <= pending_next;
      err_reg     <= err_next;
      // Coordinates are captured with the enable; colour follows a cycle later from the ROM.
      plot_reg    <= running;
      if (running) begin
        vga_x_reg   <= x_arr[idx_reg];
        vga_y_reg   <= y_arr[idx_reg];
        pix_idx_reg <= idx_reg;
      end
    end
  end

  assign vga_x       = vga_x_reg;
  assign vga_y       = vga_y_reg;
  assign plot        = plot_reg;
  assign vga_colour  = c_arr[pix_idx_reg];
  assign timeout_err = err_reg;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: behavioural drawer models with ROM-latency colour,
// a negedge monitor that scores every plotted pixel, and one task per scenario.
module tb_draw_scheduler;

  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic [3:0]  draw_mask = 4'b0000;
  logic [3:0]  en;
  logic [3:0]  done_in;
  logic [31:0] x_in;
  logic [27:0] y_in;
  logic [11:0] colour_in;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        plot;
  logic        busy;
  logic        frame_done;
  logic [3:0]  timeout_err;

  int vectors = 0;
  int miscompares = 0;

  draw_scheduler #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .draw_mask(draw_mask),
    .en(en), .done_in(done_in), .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .plot(plot),
    .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Drawer models: pixel k of drawer d sits at (bx+k%wid, by+k/wid); npix=0 means never done.
  int npix [4] = '{4, 36, 6, 7};
  int wid  [4] = '{2, 6, 3, 2};
  int bx   [4] = '{10, 148, 40, 200};
  int by   [4] = '{20, 110, 50, 100};
  int pc   [4] = '{0, 0, 0, 0};
  logic       preset_stale = 1'b0;
  logic [3:0] done_flag = 4'b0000;
  logic [2:0] col_q [4];

  function automatic logic [2:0] rom(input int d, input int k);
    return 3'((k * 5 + d * 3 + 1) % 8);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      col_q[i] <= rom(i, pc[i]);
      if (en[i] === 1'b1) begin
        pc[i] <= pc[i] + 1;
        if (npix[i] != 0 && pc[i] == npix[i] - 1) done_flag[i] <= 1'b1;
        else if (pc[i] == 0) done_flag[i] <= 1'b0;
      end else begin
        pc[i] <= 0;
      end
    end
    if (preset_stale) done_flag <= 4'hf;
  end

  always_comb begin
    x_in = '0;
    y_in = '0;
    colour_in = '0;
    done_in = '0;
    for (int i = 0; i < 4; i++) begin
      x_in[8*i +: 8]      = 8'(bx[i] + pc[i] % wid[i]);
      y_in[7*i +: 7]      = 7'(by[i] + pc[i] / wid[i]);
      colour_in[3*i +: 3] = col_q[i];
      done_in[i] = done_flag[i] | ((en[i] === 1'b1) && npix[i] != 0 && pc[i] == npix[i] - 1);
    end
  end

  // Monitor: counts enables/plots/frame_done and scores each plotted pixel.
  typedef struct {int d; int k;} exp_t;
  exp_t exp_q [$];
  exp_t cur;
  int   order_q [$];
  int   plot_cnt = 0;
  int   fd_cnt = 0;
  int   pix_bad = 0;
  int   overlap_bad = 0;
  int   en_cnt [4] = '{0, 0, 0, 0};
  int   run_k [4] = '{0, 0, 0, 0};
  int   first_x [4] = '{0, 0, 0, 0};
  int   first_y [4] = '{0, 0, 0, 0};
  logic [3:0] prev_en = 4'b0000;

  always @(negedge clk) begin
    if (plot === 1'b1) begin
      plot_cnt++;
      if (exp_q.size() == 0) begin
        pix_bad++;
      end else begin
        cur = exp_q.pop_front();
        if (vga_x !== 8'(bx[cur.d] + cur.k % wid[cur.d]) ||
            vga_y !== 7'(by[cur.d] + cur.k / wid[cur.d]) ||
            vga_colour !== rom(cur.d, cur.k))
          pix_bad++;
        if (cur.k == 0) begin
          first_x[cur.d] = int'(vga_x);
          first_y[cur.d] = int'(vga_y);
        end
      end
    end
    if (reset === 1'b1) begin
      exp_q.delete();
    end else begin
      if ($countones(en) > 1) overlap_bad++;
      for (int i = 0; i < 4; i++) begin
        if (en[i] === 1'b1) begin
          if (prev_en[i] !== 1'b1) begin
            run_k[i] = 0;
            order_q.push_back(i);
          end
          en_cnt[i]++;
          exp_q.push_back('{d: i, k: run_k[i]});
          run_k[i]++;
        end
      end
    end
    prev_en = en;
    if (frame_done === 1'b1) fd_cnt++;
  end

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic start_frame(input logic [3:0] mask);
    @(negedge clk); #1;
    draw_mask = mask;
    frame_start = 1'b1;
    @(negedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (en !== 4'b0000) begin miscompares++; $display("FAIL rst_en got=%b want=0000", en); end
    vectors++; if (plot !== 1'b0) begin miscompares++; $display("FAIL rst_plot got=%b want=0", plot); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b want=0", busy); end
    vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL rst_frame_done got=%b want=0", frame_done); end
    vectors++; if (timeout_err !== 4'b0000) begin miscompares++; $display("FAIL rst_timeout_err got=%b want=0000", timeout_err); end
    vectors++; if (vga_x !== 8'd0) begin miscompares++; $display("FAIL rst_vga_x got=%0d want=0", vga_x); end
    vectors++; if (vga_y !== 7'd0) begin miscompares++; $display("FAIL rst_vga_y got=%0d want=0", vga_y); end
    #1 reset = 1'b0;
    @(negedge clk);
    $display("test_reset: reset state checked");
  endtask

  task automatic test_empty_mask();
    int p0;
    @(negedge clk); #1;
    p0 = plot_cnt;
    draw_mask = 4'b0000;
    frame_start = 1'b1;
    @(negedge clk); #1;
    frame_start = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL empty_busy_c1 got=%b want=1", busy); end
    vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL empty_done_c1 got=%b want=0", frame_done); end
    @(negedge clk); #1;
    vectors++; if (frame_done !== 1'b1) begin miscompares++; $display("FAIL empty_done_c2 got=%b want=1", frame_done); end
    @(negedge clk); #1;
    vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL empty_done_c3 got=%b want=0", frame_done); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL empty_busy_c3 got=%b want=0", busy); end
    vectors++; if (plot_cnt - p0 !== 0) begin miscompares++; $display("FAIL empty_plots got=%0d want=0", plot_cnt - p0); end
    $display("test_empty_mask: mask=0000 frame");
  endtask

  task automatic test_single_drawer();
    int p0, f0, e0, e1, e2, e3, b0;
    bit ok;
    npix[1] = 36;
    @(negedge clk); #1;
    p0 = plot_cnt; f0 = fd_cnt; b0 = pix_bad;
    e0 = en_cnt[0]; e1 = en_cnt[1]; e2 = en_cnt[2]; e3 = en_cnt[3];
    start_frame(4'b0010);
    draw_mask = 4'b1111;
    wait_done(200, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL single_frame_done got=none want=pulse"); end
    repeat (2) @(negedge clk); #1;
    vectors++; if (plot_cnt - p0 !== 36) begin miscompares++; $display("FAIL single_plots got=%0d want=36", plot_cnt - p0); end
    vectors++; if (en_cnt[1] - e1 !== 36) begin miscompares++; $display("FAIL single_en1_cycles got=%0d want=36", en_cnt[1] - e1); end
    vectors++; if (first_x[1] !== 148) begin miscompares++; $display("FAIL single_first_x got=%0d want=148", first_x[1]); end
    vectors++; if (first_y[1] !== 110) begin miscompares++; $display("FAIL single_first_y got=%0d want=110", first_y[1]); end
    vectors++; if (pix_bad - b0 !== 0) begin miscompares++; $display("FAIL single_pixels got=%0d bad want=0", pix_bad - b0); end
    vectors++; if (fd_cnt - f0 !== 1) begin miscompares++; $display("FAIL single_frame_done_count got=%0d want=1", fd_cnt - f0); end
    vectors++; if ((en_cnt[0] - e0) + (en_cnt[2] - e2) + (en_cnt[3] - e3) !== 0) begin
      miscompares++; $display("FAIL single_mask_change got=%0d other-enable cycles want=0", (en_cnt[0] - e0) + (en_cnt[2] - e2) + (en_cnt[3] - e3));
    end
    $display("test_single_drawer: mask=0010, 36 pixels");
  endtask

  task automatic test_all_drawers();
    int p0, f0, b0, ob, o0;
    int e [4];
    int want [4] = '{4, 5, 6, 7};
    bit ok;
    npix = '{4, 5, 6, 7};
    @(negedge clk); #1 preset_stale = 1'b1;
    @(negedge clk); #1 preset_stale = 1'b0;
    p0 = plot_cnt; f0 = fd_cnt; b0 = pix_bad; ob = overlap_bad; o0 = order_q.size();
    for (int i = 0; i < 4; i++) e[i] = en_cnt[i];
    start_frame(4'b1111);
    wait_done(300, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL all_frame_done got=none want=pulse"); end
    repeat (2) @(negedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (en_cnt[i] - e[i] !== want[i]) begin miscompares++; $display("FAIL all_en%0d_cycles got=%0d want=%0d", i, en_cnt[i] - e[i], want[i]); end
    end
    vectors++; if (order_q.size() - o0 !== 4) begin miscompares++; $display("FAIL all_enable_runs got=%0d want=4", order_q.size() - o0); end
    for (int i = 0; i < 4; i++) begin
      if (o0 + i < order_q.size()) begin
        vectors++; if (order_q[o0 + i] !== i) begin miscompares++; $display("FAIL all_order_%0d got=%0d want=%0d", i, order_q[o0 + i], i); end
      end
    end
    vectors++; if (plot_cnt - p0 !== 22) begin miscompares++; $display("FAIL all_plots got=%0d want=22", plot_cnt - p0); end
    vectors++; if (overlap_bad - ob !== 0) begin miscompares++; $display("FAIL all_overlap got=%0d want=0", overlap_bad - ob); end
    vectors++; if (pix_bad - b0 !== 0) begin miscompares++; $display("FAIL all_pixels got=%0d bad want=0", pix_bad - b0); end
    vectors++; if (fd_cnt - f0 !== 1) begin miscompares++; $display("FAIL all_frame_done_count got=%0d want=1", fd_cnt - f0); end
    $display("test_all_drawers: mask=1111 with stale done");
  endtask

  task automatic test_timeout();
    int p0, f0, b0, e2, e3, o0;
    bit ok;
    npix[2] = 0;
    npix[3] = 4;
    @(negedge clk); #1;
    p0 = plot_cnt; f0 = fd_cnt; b0 = pix_bad; e2 = en_cnt[2]; e3 = en_cnt[3]; o0 = order_q.size();
    start_frame(4'b1100);
    wait_done(400, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL to_frame_done got=none want=pulse"); end
    repeat (2) @(negedge clk); #1;
    vectors++; if (en_cnt[2] - e2 !== TO) begin miscompares++; $display("FAIL to_en2_cycles got=%0d want=%0d", en_cnt[2] - e2, TO); end
    vectors++; if (en_cnt[3] - e3 !== 4) begin miscompares++; $display("FAIL to_en3_cycles got=%0d want=4", en_cnt[3] - e3); end
    vectors++; if (timeout_err !== 4'b0100) begin miscompares++; $display("FAIL to_err got=%b want=0100", timeout_err); end
    vectors++; if (order_q.size() - o0 !== 2) begin miscompares++; $display("FAIL to_enable_runs got=%0d want=2", order_q.size() - o0); end
    if (order_q.size() - o0 == 2) begin
      vectors++; if (order_q[o0 + 1] !== 3) begin miscompares++; $display("FAIL to_next_drawer got=%0d want=3", order_q[o0 + 1]); end
    end
    vectors++; if (plot_cnt - p0 !== TO + 4) begin miscompares++; $display("FAIL to_plots got=%0d want=%0d", plot_cnt - p0, TO + 4); end
    vectors++; if (pix_bad - b0 !== 0) begin miscompares++; $display("FAIL to_pixels got=%0d bad want=0", pix_bad - b0); end
    vectors++; if (fd_cnt - f0 !== 1) begin miscompares++; $display("FAIL to_frame_done_count got=%0d want=1", fd_cnt - f0); end
    $display("test_timeout: drawer 2 abandoned after %0d cycles", TO);
  endtask

  task automatic test_back_to_back();
    int f0, e0, e1;
    bit ok1, ok2;
    npix = '{4, 5, 6, 7};
    @(negedge clk); #1;
    f0 = fd_cnt; e0 = en_cnt[0]; e1 = en_cnt[1];
    start_frame(4'b0011);
    for (int p = 0; p < 3; p++) begin
      repeat (2) @(negedge clk);
      #1 frame_start = 1'b1;
      @(negedge clk);
      #1 frame_start = 1'b0;
    end
    wait_done(100, ok1);
    wait_done(100, ok2);
    vectors++; if (!(ok1 && ok2)) begin miscompares++; $display("FAIL b2b_two_frames got=%0d%0d want=11", ok1, ok2); end
    repeat (30) @(negedge clk); #1;
    vectors++; if (fd_cnt - f0 !== 2) begin miscompares++; $display("FAIL b2b_frame_done_count got=%0d want=2", fd_cnt - f0); end
    vectors++; if (en_cnt[0] - e0 !== 8) begin miscompares++; $display("FAIL b2b_en0_cycles got=%0d want=8", en_cnt[0] - e0); end
    vectors++; if (en_cnt[1] - e1 !== 10) begin miscompares++; $display("FAIL b2b_en1_cycles got=%0d want=10", en_cnt[1] - e1); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle got=%b want=0", busy); end
    vectors++; if (timeout_err !== 4'b0100) begin miscompares++; $display("FAIL b2b_err_sticky got=%b want=0100", timeout_err); end
    $display("test_back_to_back: 3 requests while busy");
  endtask

  task automatic test_pending_at_finish();
    int f0;
    @(negedge clk); #1;
    f0 = fd_cnt;
    draw_mask = 4'b0000;
    frame_start = 1'b1;
    @(negedge clk); #1;
    frame_start = 1'b0;
    @(negedge clk);
    vectors++; if (frame_done !== 1'b1) begin miscompares++; $display("FAIL paf_done_c2 got=%b want=1", frame_done); end
    #1 frame_start = 1'b1;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL paf_idle_c3 got=%b want=0", busy); end
    #1 frame_start = 1'b0;
    @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL paf_busy_c4 got=%b want=1", busy); end
    @(negedge clk);
    vectors++; if (frame_done !== 1'b1) begin miscompares++; $display("FAIL paf_done_c5 got=%b want=1", frame_done); end
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL paf_idle_c6 got=%b want=0", busy); end
    #1;
    vectors++; if (fd_cnt - f0 !== 2) begin miscompares++; $display("FAIL paf_frame_done_count got=%0d want=2", fd_cnt - f0); end
    $display("test_pending_at_finish: request during FINISH");
  endtask

  task automatic test_reset_mid_frame();
    int f0;
    bit seen;
    npix[1] = 36;
    @(negedge clk); #1;
    f0 = fd_cnt;
    start_frame(4'b0010);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (en[1] === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL rmf_en1_seen got=0 want=1"); end
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    vectors++; if (en !== 4'b0000) begin miscompares++; $display("FAIL rmf_en got=%b want=0000", en); end
    vectors++; if (plot !== 1'b0) begin miscompares++; $display("FAIL rmf_plot got=%b want=0", plot); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmf_busy got=%b want=0", busy); end
    vectors++; if (timeout_err !== 4'b0000) begin miscompares++; $display("FAIL rmf_err_cleared got=%b want=0000", timeout_err); end
    #1 reset = 1'b0;
    repeat (10) @(negedge clk); #1;
    vectors++; if (fd_cnt - f0 !== 0) begin miscompares++; $display("FAIL rmf_frame_done got=%0d want=0", fd_cnt - f0); end
    $display("test_reset_mid_frame: reset during drawer 1");
  endtask

  initial begin
    test_reset();
    test_empty_mask();
    test_single_drawer();
    test_all_drawers();
    test_timeout();
    test_back_to_back();
    test_pending_at_finish();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
